// File: rtl/fft_pkg.sv
// Shared types and constants for the 8-point FFT stage sequencer.
// Samples are packed complex words: real part in the upper half, imaginary in the lower.
package fft_pkg;

    localparam int FFT_DW   = 64;
    localparam int FFT_NPTS = 8;

    typedef struct packed {
        logic signed [31:0] re;
        logic signed [31:0] im;
    } cplx_t;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        WAIT,
        DRAIN
    } seq_state_t;

endpackage

// File: rtl/fft_frame_buf.sv
// N x DW frame register file: serial write port, parallel load port, parallel read bus.
// The read bus shows the pending serial write, so a frame can be taken whole on its last beat.
module fft_frame_buf
    import fft_pkg::*;
#(
    parameter int N  = FFT_NPTS,
    parameter int DW = FFT_DW
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic [$clog2(N)-1:0] wr_addr,
    input  logic [DW-1:0]        wr_data,
    input  logic                 ld_en,
    input  logic [N*DW-1:0]      ld_data,
    output logic [N*DW-1:0]      rd_bus
);

    logic [DW-1:0] mem [N];

    // NOTE: the storage is reset because the output buffer feeds out_data, which must read 0 out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++) mem[i] <= '0;
        end else if (ld_en) begin
            for (int i = 0; i < N; i++) mem[i] <= ld_data[i*DW +: DW];
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        rd_bus = '0;
        for (int i = 0; i < N; i++) begin
            rd_bus[i*DW +: DW] = (wr_en && wr_addr == ($clog2(N))'(i)) ? wr_data : mem[i];
        end
    end

endmodule

// File: rtl/fft8_stage_seq.sv
// Frame sequencer around one registered 8-point butterfly stage: serial in, parallel stage, serial out.
// Optional build macro FFT_SEQ_FRAME_CNT_EN adds a 16-bit count of fully drained frames.
module fft8_stage_seq
    import fft_pkg::*;
#(
    parameter int N_PTS  = FFT_NPTS,
    parameter int DW     = FFT_DW,
    parameter int BF_LAT = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [DW-1:0]       in_data,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [N_PTS*DW-1:0] bf_in,
    input  logic [N_PTS*DW-1:0] bf_out,
    output logic [DW-1:0]       out_data,
    output logic [2:0]          out_idx,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                busy
`ifdef FFT_SEQ_FRAME_CNT_EN
    ,
    output logic [15:0]         frame_cnt
`endif
);

    localparam int              PW       = $clog2(N_PTS);
    localparam logic [PW-1:0]   LAST_IDX = PW'(N_PTS - 1);
    localparam logic [2:0]      LAT_END  = 3'(BF_LAT);

    seq_state_t          state, state_nxt;
    logic [PW-1:0]       wr_ptr, rd_ptr;
    logic [2:0]          lat_cnt;
    logic                in_beat, out_beat, last_in_beat, last_out_beat, capture;
    logic [N_PTS*DW-1:0] ibuf_bus, obuf_bus;

    // Handshake outputs depend on registered state only, never on in_valid/out_ready.
    assign in_ready      = (state == LOAD);
    assign out_valid     = (state == DRAIN);
    assign busy          = (state != IDLE);
    assign out_idx       = 3'(rd_ptr);

    assign in_beat       = in_ready && in_valid;
    assign out_beat      = out_valid && out_ready;
    assign last_in_beat  = in_beat && (wr_ptr == LAST_IDX);
    assign last_out_beat = out_beat && (rd_ptr == LAST_IDX);
    assign capture       = (state == WAIT) && (lat_cnt == LAT_END);

    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    state_nxt = LOAD;
            LOAD:    if (last_in_beat)  state_nxt = WAIT;
            WAIT:    if (capture)       state_nxt = DRAIN;
            DRAIN:   if (last_out_beat) state_nxt = LOAD;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            lat_cnt <= '0;
            bf_in   <= '0;
        end else begin
            state <= state_nxt;
            if (in_beat)  wr_ptr <= wr_ptr + 1'b1;
            if (out_beat) rd_ptr <= rd_ptr + 1'b1;
            if (last_in_beat) begin
                lat_cnt <= '0;
                bf_in   <= ibuf_bus;
            end else if (state == WAIT && lat_cnt != LAT_END) begin
                lat_cnt <= lat_cnt + 3'd1;
            end
        end
    end

    fft_frame_buf #(.N(N_PTS), .DW(DW)) u_ibuf (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (in_beat),
        .wr_addr (wr_ptr),
        .wr_data (in_data),
        .ld_en   (1'b0),
        .ld_data ('0),
        .rd_bus  (ibuf_bus)
    );

    fft_frame_buf #(.N(N_PTS), .DW(DW)) u_obuf (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (1'b0),
        .wr_addr ('0),
        .wr_data ('0),
        .ld_en   (capture),
        .ld_data (bf_out),
        .rd_bus  (obuf_bus)
    );

    always_comb begin
        out_data = '0;
        for (int i = 0; i < N_PTS; i++) begin
            if (rd_ptr == PW'(i)) out_data = obuf_bus[i*DW +: DW];
        end
    end

`ifdef FFT_SEQ_FRAME_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                frame_cnt <= '0;
        else if (last_out_beat) frame_cnt <= frame_cnt + 16'd1;
    end
`else
    // No frame counter in this build.
`endif

endmodule
